axis_pkt_ctrl: RTL and testbench
================================

# axis_pkt_ctrl

Packet sequencer placed between the power-of-3 stream generator and the downstream AXI-Stream sink. On a start command it enables the source and forwards a programmed number of packets of a programmed beat length. It inserts tlast on the final beat of each packet and idles the source for a programmed gap between packets. It reports busy/done/error to the control side.

## Interface
- DATA_SIZE, 32, stream data width (multiple of 8)
- LEN_W, 16, width of packet-length field
- CNT_W, 16, width of packet-count field
- GAP_W, 8, width of inter-packet gap field

- axis_aclk  in  1  single clock, all logic on rising edge
- axis_areset  in  1  reset, synchronous, active-high
- cfg_start  in  1  start pulse; sampled only in IDLE
- cfg_abort  in  1  abort request; effective in RUN/GAP
- cfg_pkt_len  in  LEN_W  beats per packet; latched on start
- cfg_pkt_count  in  CNT_W  packets per run; latched on start
- cfg_gap  in  GAP_W  idle cycles between packets; latched on start
- src_enable  out  1  enable to the source generator
- s00_axis_tdata  in  DATA_SIZE  source data
- s00_axis_tvalid  in  1  source valid
- s00_axis_tready  out  1  ready to source
- m00_axis_tdata  out  DATA_SIZE  output data
- m00_axis_tstrb  out  DATA_SIZE/8  output byte strobes
- m00_axis_tvalid  out  1  output valid
- m00_axis_tready  in  1  downstream ready
- m00_axis_tlast  out  1  last beat of packet
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a run ends (complete or aborted)
- aborted  out  1  high with done when the run ended by abort; cleared on next start
- cfg_err  out  1  one-cycle pulse when start is rejected

## Operation
- States: IDLE, RUN, GAP, FLUSH.
- IDLE: if cfg_start, with cfg_pkt_len != 0 and cfg_pkt_count != 0: latch the config, clear the beat and packet counters and aborted, then go to RUN. If cfg_start with either field zero: pulse cfg_err and stay in IDLE.
- src_enable = (state == RUN).
- s00_axis_tready = (state == RUN) && (!m00_axis_tvalid || m00_axis_tready).
- Accept = s00_axis_tvalid && s00_axis_tready. Each accept loads the output register:
  - tdata is the source data.
  - tstrb is all ones.
  - tlast = (beat_cnt == pkt_len-1).
- Beat counter increments on accept and wraps to 0 on the last beat. The packet counter increments on each last-beat accept.
- RUN, last-beat accept:
  - If it is the final packet, go to FLUSH.
  - Else if gap == 0, stay in RUN (back-to-back packets).
  - Else go to GAP with the gap counter = gap.
- GAP: decrement the gap counter each cycle. When it reaches 1, go to RUN, so RUN is re-entered after exactly gap cycles.
- FLUSH: wait until the output register is empty or drains (m00_axis_tvalid && m00_axis_tready). Then pulse done and go to IDLE.
- Abort in RUN or GAP: go to FLUSH and set aborted. No further accepts occur. A beat already in the output register is delivered unchanged, so the packet may end without tlast. Abort in IDLE or FLUSH is ignored.
- Abort and last-beat accept in the same cycle: the beat is accepted with its normal tlast. Abort takes priority for the state transition.
- cfg_start outside IDLE is ignored. Config changes after the start latch have no effect.

## Timing
- Reset values:
  - state = IDLE.
  - m00_axis_tdata = 0, tstrb = 0, tvalid = 0, tlast = 0.
  - src_enable, s00_axis_tready, busy, done, aborted, cfg_err all 0.
  - All counters 0.
- Reset mid-run returns to IDLE the next cycle and discards any in-flight beat.
- Latency is 1 cycle from accept to m00_axis_tvalid.
- Throughput is 1 beat/cycle while m00_axis_tready is high.
- m00_axis_tvalid, tdata, tstrb and tlast hold stable until m00_axis_tready.
- When the output register is empty, tstrb = 0 and tlast = 0.
- start to src_enable: 1 cycle. done: asserted the cycle after the final output handshake, or the cycle after entering FLUSH with the register empty.

## Configuration
- Macro AXIS_PKT_CTRL_STATS_EN.
- Defined: adds outputs stat_beats (32 bits) and stat_pkts (CNT_W bits).
  - stat_beats counts m00_axis handshakes; stat_pkts counts handshakes with tlast.
  - Both clear on start and on reset, saturate at all ones, and hold after done.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Structure
- Package axis_pkt_ctrl_pkg holds:
  - the state enum (IDLE, RUN, GAP, FLUSH);
  - default widths LEN_W/CNT_W/GAP_W;
  - the stats counter width constant.
- One sub-module, axis_out_reg: a one-entry AXI-Stream output register with load/hold/drain and a tvalid/tready interface. The FSM and counters stay in the top level.

## Test plan
- len=4, count=2, gap=3, tready=1, source 1,3,9,...:
  - output 1,3,9,27 (tlast on 27), then 3 cycles with src_enable=0, then 81,243,729,2187 (tlast on 2187);
  - done pulses once, busy falls with done.
- len=3, count=1, m00_axis_tready toggling 1/0 every cycle: no beat lost or duplicated, data held while tready=0, tlast on the 3rd beat only.
- start with len=0, then with count=0: cfg_err pulses each time, busy stays 0, src_enable stays 0.
- len=8, count=1, abort asserted after the 3rd accept: at most one more beat is delivered, done=1 with aborted=1, 0 beats delivered after done.
- gap=0, len=2, count=3: 6 consecutive beats with tlast on beats 2, 4 and 6, and no idle cycle.
- reset asserted while in GAP: next cycle all outputs at their reset values; a following start runs normally.

Source files
------------

// File: rtl/axis_pkt_ctrl_pkg.sv
// Shared types and default widths for the axis_pkt_ctrl packet sequencer.
package axis_pkt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        GAP   = 2'd2,
        FLUSH = 2'd3
    } state_e;

    localparam int DEF_LEN_W    = 16;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_GAP_W    = 8;
    localparam int STAT_BEATS_W = 32;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register: load when empty or draining, hold while
// stalled, and clear strobes/last once the beat has been taken.
module axis_out_reg
    import axis_pkt_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [DATA_SIZE-1:0]   data_i,
    input  logic                   last_i,
    input  logic                   ready_i,
    output logic [DATA_SIZE-1:0]   tdata_o,
    output logic [DATA_SIZE/8-1:0] tstrb_o,
    output logic                   tvalid_o,
    output logic                   tlast_o
);

    logic [DATA_SIZE-1:0]   tdata_q, tdata_d;
    logic [DATA_SIZE/8-1:0] tstrb_q, tstrb_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;

    always_comb begin
        tdata_d  = tdata_q;
        tstrb_d  = tstrb_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        if (load_i) begin
            tdata_d  = data_i;
            tstrb_d  = '1;
            tvalid_d = 1'b1;
            tlast_d  = last_i;
        end else if (tvalid_q && ready_i) begin
            // Data is left as-is on drain; only the qualifiers are cleared.
            tstrb_d  = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tdata_q  <= '0;
            tstrb_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tstrb_q  <= tstrb_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign tdata_o  = tdata_q;
    assign tstrb_o  = tstrb_q;
    assign tvalid_o = tvalid_q;
    assign tlast_o  = tlast_q;

endmodule

// File: rtl/axis_pkt_ctrl.sv
// Packet sequencer: forwards cfg_pkt_count packets of cfg_pkt_len beats with cfg_gap idle
// cycles between them. Define AXIS_PKT_CTRL_STATS_EN to add stat_beats/stat_pkts outputs.
module axis_pkt_ctrl
    import axis_pkt_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int GAP_W     = DEF_GAP_W
) (
    input  logic                   axis_aclk,
    input  logic                   axis_areset,
    input  logic                   cfg_start,
    input  logic                   cfg_abort,
    input  logic [LEN_W-1:0]       cfg_pkt_len,
    input  logic [CNT_W-1:0]       cfg_pkt_count,
    input  logic [GAP_W-1:0]       cfg_gap,
    output logic                   src_enable,
    input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
    input  logic                   s00_axis_tvalid,
    output logic                   s00_axis_tready,
    output logic [DATA_SIZE-1:0]   m00_axis_tdata,
    output logic [DATA_SIZE/8-1:0] m00_axis_tstrb,
    output logic                   m00_axis_tvalid,
    input  logic                   m00_axis_tready,
    output logic                   m00_axis_tlast,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic                   cfg_err
`ifdef AXIS_PKT_CTRL_STATS_EN
    ,
    output logic [STAT_BEATS_W-1:0] stat_beats,
    output logic [CNT_W-1:0]        stat_pkts
`endif
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d, beat_q, beat_d;
    logic [CNT_W-1:0]   count_q, count_d, pkt_q, pkt_d;
    logic [GAP_W-1:0]   gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic               aborted_q, aborted_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;
    logic               start_ok, accept, last_beat;

    assign start_ok  = (state_q == IDLE) && cfg_start && (cfg_pkt_len != '0) && (cfg_pkt_count != '0);
    assign accept    = s00_axis_tvalid && s00_axis_tready;
    assign last_beat = (beat_q == len_q - LEN_W'(1));

    assign src_enable      = (state_q == RUN);
    assign s00_axis_tready = (state_q == RUN) && (!m00_axis_tvalid || m00_axis_tready);
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign cfg_err         = cfg_err_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        gap_d     = gap_q;
        beat_d    = beat_q;
        pkt_d     = pkt_q;
        gap_cnt_d = gap_cnt_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    len_d     = cfg_pkt_len;
                    count_d   = cfg_pkt_count;
                    gap_d     = cfg_gap;
                    beat_d    = '0;
                    pkt_d     = '0;
                    gap_cnt_d = '0;
                    aborted_d = 1'b0;
                    state_d   = RUN;
                end else if (cfg_start) begin
                    cfg_err_d = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_beat) begin
                        beat_d = '0;
                        pkt_d  = pkt_q + CNT_W'(1);
                        if (pkt_q == count_q - CNT_W'(1)) begin
                            state_d = FLUSH;
                        end else if (gap_q != '0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
                // A coincident abort still lets this cycle's beat through but wins the transition.
                if (cfg_abort) begin
                    state_d   = FLUSH;
                    aborted_d = 1'b1;
                end
            end
            GAP: begin
                if (cfg_abort) begin
                    state_d   = FLUSH;
                    aborted_d = 1'b1;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = RUN;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            FLUSH: begin
                if (!m00_axis_tvalid || m00_axis_tready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            count_q   <= '0;
            gap_q     <= '0;
            beat_q    <= '0;
            pkt_q     <= '0;
            gap_cnt_q <= '0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            beat_q    <= beat_d;
            pkt_q     <= pkt_d;
            gap_cnt_q <= gap_cnt_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    axis_out_reg #(
        .DATA_SIZE(DATA_SIZE)
    ) u_out_reg (
        .clk_i    (axis_aclk),
        .rst_i    (axis_areset),
        .load_i   (accept),
        .data_i   (s00_axis_tdata),
        .last_i   (last_beat),
        .ready_i  (m00_axis_tready),
        .tdata_o  (m00_axis_tdata),
        .tstrb_o  (m00_axis_tstrb),
        .tvalid_o (m00_axis_tvalid),
        .tlast_o  (m00_axis_tlast)
    );

`ifdef AXIS_PKT_CTRL_STATS_EN
    logic [STAT_BEATS_W-1:0] stat_beats_q;
    logic [CNT_W-1:0]        stat_pkts_q;
    logic                    out_hs;

    assign out_hs = m00_axis_tvalid && m00_axis_tready;

    always_ff @(posedge axis_aclk) begin
        if (axis_areset || start_ok) begin
            stat_beats_q <= '0;
            stat_pkts_q  <= '0;
        end else if (out_hs) begin
            if (!(&stat_beats_q)) stat_beats_q <= stat_beats_q + STAT_BEATS_W'(1);
            if (m00_axis_tlast && !(&stat_pkts_q)) stat_pkts_q <= stat_pkts_q + CNT_W'(1);
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_pkts  = stat_pkts_q;
`endif

endmodule

// File: tb/tb_axis_pkt_ctrl.sv
// Directed self-checking bench for axis_pkt_ctrl driven by a power-of-3 source model.
module tb_axis_pkt_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [15:0] cfg_pkt_len = '0;
    logic [15:0] cfg_pkt_count = '0;
    logic [7:0]  cfg_gap = '0;
    logic        src_enable;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        busy, done, aborted, cfg_err;
`ifdef AXIS_PKT_CTRL_STATS_EN
    logic [31:0] stat_beats;
    logic [15:0] stat_pkts;
`endif

    axis_pkt_ctrl dut (
        .axis_aclk       (clk),
        .axis_areset     (rst),
        .cfg_start       (cfg_start),
        .cfg_abort       (cfg_abort),
        .cfg_pkt_len     (cfg_pkt_len),
        .cfg_pkt_count   (cfg_pkt_count),
        .cfg_gap         (cfg_gap),
        .src_enable      (src_enable),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .m00_axis_tlast  (m_tlast),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .cfg_err         (cfg_err)
`ifdef AXIS_PKT_CTRL_STATS_EN
        ,
        .stat_beats      (stat_beats),
        .stat_pkts       (stat_pkts)
`endif
    );

    always #5 clk = ~clk;

    // Source model: always valid while enabled, next power of 3 after each accept.
    logic [31:0] pow3 = 32'd1;
    logic        src_restart = 1'b0;
    assign s_tvalid = src_enable;
    assign s_tdata  = pow3;

    always @(posedge clk) begin
        if (src_restart) pow3 <= 32'd1;
        else if (s_tvalid && s_tready) pow3 <= pow3 * 32'd3;
    end

    // Output monitor and hold checker.
    logic [31:0] cap_data[$];
    logic        cap_last[$];
    int          cap_cyc[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          hold_err = 0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_d = '0;
    logic        hold_l = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            hold_pend <= 1'b0;
        end else begin
            if (m_tvalid && m_tready) begin
                cap_data.push_back(m_tdata);
                cap_last.push_back(m_tlast);
                cap_cyc.push_back(cyc);
            end
            if (s_tvalid && s_tready) acc_cnt <= acc_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (hold_pend && (m_tvalid !== 1'b1 || m_tdata !== hold_d || m_tlast !== hold_l))
                hold_err <= hold_err + 1;
            hold_pend <= m_tvalid && !m_tready;
            hold_d    <= m_tdata;
            hold_l    <= m_tlast;
        end
    end

    int n_total = 0;
    int n_pass  = 0;
    int qbase, abase, dbase, hbase;
    int unsigned p3[8] = '{32'd1, 32'd3, 32'd9, 32'd27, 32'd81, 32'd243, 32'd729, 32'd2187};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int nbeats();
        return cap_data.size() - qbase;
    endfunction

    function automatic logic [31:0] beat_data(input int i);
        if (qbase + i < cap_data.size()) return cap_data[qbase + i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int beat_cyc(input int i);
        if (qbase + i < cap_cyc.size()) return cap_cyc[qbase + i];
        return -1000;
    endfunction

    function automatic logic [31:0] last_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < nbeats() && i < 32; i++) v[i] = cap_last[qbase + i];
        return v;
    endfunction

    task automatic check_data(input string tag, input int n);
        for (int i = 0; i < n; i++) chk($sformatf("%s_data%0d", tag, i), beat_data(i), p3[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts a run and waits (bounded) for done, optionally toggling tready or aborting.
    task automatic run(input string tag, input int len, input int cnt, input int gap,
                       input bit tog, input int abort_at, input int budget);
        bit got_done = 1'b0;
        bit sent = 1'b0;
        @(negedge clk);
        qbase = cap_data.size();
        abase = acc_cnt;
        dbase = done_cnt;
        hbase = hold_err;
        cfg_pkt_len   = 16'(len);
        cfg_pkt_count = 16'(cnt);
        cfg_gap       = 8'(gap);
        cfg_start     = 1'b1;
        src_restart   = 1'b1;
        @(negedge clk);
        cfg_start   = 1'b0;
        src_restart = 1'b0;
        for (int i = 0; i < budget && !got_done; i++) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (tog) m_tready = ~m_tready;
                if (!sent && abort_at > 0 && (acc_cnt - abase) == abort_at) begin
                    cfg_abort = 1'b1;
                    sent = 1'b1;
                end else begin
                    cfg_abort = 1'b0;
                end
                @(negedge clk);
            end
        end
        cfg_abort = 1'b0;
        m_tready  = 1'b1;
        chk({tag, "_done_seen"}, got_done, 1'b1);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", {m_tvalid, m_tlast, busy, done, aborted, cfg_err, src_enable, s_tready}, 8'h00);
        chk("rst_tdata", m_tdata, 32'h0);
        chk("rst_tstrb", m_tstrb, 4'h0);

        // Two packets of four with a three-cycle gap.
        run("t1", 4, 2, 3, 1'b0, 0, 200);
        chk("t1_beats", nbeats(), 8);
        check_data("t1", 8);
        chk("t1_last", last_vec(), 32'b1000_1000);
        chk("t1_burst", beat_cyc(3) - beat_cyc(0), 3);
        chk("t1_gap", beat_cyc(4) - beat_cyc(3), 4);
        chk("t1_aborted", aborted, 1'b0);
        idle(4);
        chk("t1_done_once", done_cnt - dbase, 1);
`ifdef AXIS_PKT_CTRL_STATS_EN
        chk("t1_stat_beats", stat_beats, 32'd8);
        chk("t1_stat_pkts", stat_pkts, 32'd2);
`endif

        // Downstream backpressure toggling every cycle.
        run("t2", 3, 1, 0, 1'b1, 0, 200);
        chk("t2_beats", nbeats(), 3);
        check_data("t2", 3);
        chk("t2_last", last_vec(), 32'b100);
        chk("t2_hold", hold_err - hbase, 0);

        // Rejected starts: zero length, then zero count.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cfg_pkt_len   = (k == 0) ? 16'd0 : 16'd4;
            cfg_pkt_count = (k == 0) ? 16'd2 : 16'd0;
            cfg_start     = 1'b1;
            @(negedge clk);
            cfg_start = 1'b0;
            chk($sformatf("t3_err%0d", k), cfg_err, 1'b1);
            chk($sformatf("t3_busy%0d", k), {busy, src_enable}, 2'b00);
            @(negedge clk);
            chk($sformatf("t3_pulse%0d", k), {cfg_err, busy, src_enable}, 3'b000);
        end

        // Abort after the third accept; the coincident fourth beat still drains.
        run("t4", 8, 1, 0, 1'b0, 3, 200);
        chk("t4_aborted", aborted, 1'b1);
        chk("t4_beats", nbeats(), 4);
        check_data("t4", 4);
        chk("t4_last", last_vec(), 32'b0);
        idle(5);
        chk("t4_no_more", nbeats(), 4);
        chk("t4_aborted_hold", aborted, 1'b1);

        // Back-to-back packets with no gap.
        run("t5", 2, 3, 0, 1'b0, 0, 200);
        chk("t5_beats", nbeats(), 6);
        check_data("t5", 6);
        chk("t5_last", last_vec(), 32'b10_1010);
        chk("t5_span", beat_cyc(5) - beat_cyc(0), 5);

        // Reset while idling in the gap, then a clean run.
        @(negedge clk);
        abase = acc_cnt;
        cfg_pkt_len = 16'd4; cfg_pkt_count = 16'd2; cfg_gap = 8'd5;
        cfg_start = 1'b1; src_restart = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0; src_restart = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if ((acc_cnt - abase) == 4) seen = 1'b1;
            else @(negedge clk);
        end
        chk("t6_reach_gap", seen, 1'b1);
        chk("t6_in_gap", {busy, src_enable}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_ctrl", {m_tvalid, m_tlast, busy, done, aborted, cfg_err, src_enable, s_tready}, 8'h00);
        chk("t6_rst_data", {m_tdata, m_tstrb}, 36'h0);
        rst = 1'b0;
        run("t6", 2, 1, 0, 1'b0, 0, 100);
        chk("t6_beats", nbeats(), 2);
        check_data("t6", 2);
        chk("t6_last", last_vec(), 32'b10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
